register_module: RTL and testbench

- Small CPU register bank. It captures the 8-bit ALU result into one of NUM_REGS registers when save is asserted.
- It presents a selected register on data_out, with zero and negative status flags and per-register "written" bits.
- It sits between the ALU output and the operand/writeback path of the 8-bit CPU.

---
 rtl/register_module_if.sv | 26 ++
 rtl/register_module.sv | 40 ++++
 tb/tb_register_module.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/register_module_if.sv
// Bus between the ALU/writeback path and the register bank: write port,
// read select, and the read data with its status flags.
interface register_module_if #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2
);
  logic                save;
  logic [SEL_W-1:0]    wr_sel;
  logic [WIDTH-1:0]    alu_out;
  logic [SEL_W-1:0]    rd_sel;
  logic [WIDTH-1:0]    data_out;
  logic                zero;
  logic                neg;
  logic [NUM_REGS-1:0] written;

  modport master (
    output save, wr_sel, alu_out, rd_sel,
    input  data_out, zero, neg, written
  );

  modport slave (
    input  save, wr_sel, alu_out, rd_sel,
    output data_out, zero, neg, written
  );
endinterface

// File: rtl/register_module.sv
// CPU register bank: captures alu_out into reg[wr_sel] on save, reads
// reg[rd_sel] combinationally with zero/neg flags and per-register written bits.
module register_module #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2
) (
  input logic              clk,
  input logic              reset,
  register_module_if.slave bus
);

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] written_q;
  logic [WIDTH-1:0]    rd_data;

  // Reset is asynchronous and overrides a save presented in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      written_q <= '0;
    end else if (bus.save) begin
      regs[bus.wr_sel]      <= bus.alu_out;
      written_q[bus.wr_sel] <= 1'b1;
    end
  end

  // Read from stored state only; a write becomes visible after its edge.
  always_comb begin
    rd_data = regs[bus.rd_sel];
  end

  assign bus.data_out = rd_data;
  assign bus.zero     = (rd_data == '0);
  assign bus.neg      = rd_data[WIDTH-1];
  assign bus.written  = written_q;

endmodule

// File: tb/tb_register_module.sv
// Directed bench for register_module: vector table plus hand sequences for
// pre-edge visibility and asynchronous reset during a save.
module tb_register_module;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  register_module_if #(.WIDTH(8), .NUM_REGS(4), .SEL_W(2)) bus ();

  register_module #(.WIDTH(8), .NUM_REGS(4), .SEL_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       save;
    logic [1:0] wr_sel;
    logic [7:0] alu;
    logic [1:0] rd_sel;
    logic       tick;
    logic [7:0] exp_d;
    logic       exp_z;
    logic       exp_n;
    logic [3:0] exp_w;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic z,
                           input logic n, input logic [3:0] w);
    check({tag, ".data_out"}, 32'(bus.data_out), 32'(d));
    check({tag, ".zero"},     32'(bus.zero),     32'(z));
    check({tag, ".neg"},      32'(bus.neg),      32'(n));
    check({tag, ".written"},  32'(bus.written),  32'(w));
  endtask

  initial begin
    tests = 0;
    fails = 0;

    //          save wr   alu    rd   tick  d      z     n     w
    vecs[0]  = '{1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0000};
    vecs[1]  = '{1'b1, 2'd0, 8'hAA, 2'd0, 1'b1, 8'hAA, 1'b0, 1'b1, 4'b0001};
    vecs[2]  = '{1'b0, 2'd0, 8'h55, 2'd0, 1'b1, 8'hAA, 1'b0, 1'b1, 4'b0001};
    vecs[3]  = '{1'b0, 2'd1, 8'h55, 2'd0, 1'b1, 8'hAA, 1'b0, 1'b1, 4'b0001};
    vecs[4]  = '{1'b1, 2'd2, 8'h55, 2'd2, 1'b1, 8'h55, 1'b0, 1'b0, 4'b0101};
    vecs[5]  = '{1'b0, 2'd2, 8'h55, 2'd0, 1'b0, 8'hAA, 1'b0, 1'b1, 4'b0101};
    vecs[6]  = '{1'b1, 2'd3, 8'h00, 2'd3, 1'b1, 8'h00, 1'b1, 1'b0, 4'b1101};
    vecs[7]  = '{1'b1, 2'd1, 8'h01, 2'd1, 1'b1, 8'h01, 1'b0, 1'b0, 4'b1111};
    vecs[8]  = '{1'b1, 2'd1, 8'h80, 2'd1, 1'b1, 8'h80, 1'b0, 1'b1, 4'b1111};
    vecs[9]  = '{1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 8'hAA, 1'b0, 1'b1, 4'b1111};
    vecs[10] = '{1'b0, 2'd0, 8'h00, 2'd1, 1'b0, 8'h80, 1'b0, 1'b1, 4'b1111};
    vecs[11] = '{1'b0, 2'd0, 8'h00, 2'd2, 1'b0, 8'h55, 1'b0, 1'b0, 4'b1111};
    vecs[12] = '{1'b0, 2'd0, 8'h00, 2'd3, 1'b0, 8'h00, 1'b1, 1'b0, 4'b1111};
    vecs[13] = '{1'b1, 2'd0, 8'h7F, 2'd0, 1'b1, 8'h7F, 1'b0, 1'b0, 4'b1111};
    vecs[14] = '{1'b1, 2'd3, 8'hFF, 2'd3, 1'b1, 8'hFF, 1'b0, 1'b1, 4'b1111};

    bus.save    = 1'b0;
    bus.wr_sel  = 2'd0;
    bus.alu_out = 8'h00;
    bus.rd_sel  = 2'd0;

    // Power-up reset, with save held high to show it is ignored.
    reset    = 1'b0;
    bus.save = 1'b1;
    bus.alu_out = 8'hEE;
    #10;
    bus.save = 1'b0;
    reset    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rd_sel = 2'(i);
      #1;
      check_out($sformatf("por_rd%0d", i), 8'h00, 1'b1, 1'b0, 4'b0000);
    end

    // Before-edge visibility of the first write.
    @(negedge clk);
    bus.save = 1'b0; bus.wr_sel = 2'd0; bus.alu_out = 8'hAA; bus.rd_sel = 2'd0;
    #1;
    check("pre_edge.data_out", 32'(bus.data_out), 32'h00);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.save    = vecs[i].save;
      bus.wr_sel  = vecs[i].wr_sel;
      bus.alu_out = vecs[i].alu;
      bus.rd_sel  = vecs[i].rd_sel;
      if (vecs[i].tick) begin
        @(posedge clk);
        #1;
        bus.save = 1'b0;
      end else begin
        #1;
      end
      check_out($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_z,
                vecs[i].exp_n, vecs[i].exp_w);
    end

    // Save and read the same register: old value until the edge, then new.
    @(negedge clk);
    bus.save = 1'b1; bus.wr_sel = 2'd2; bus.alu_out = 8'h3C; bus.rd_sel = 2'd2;
    #1;
    check("same_reg.before", 32'(bus.data_out), 32'h55);
    @(posedge clk);
    #1;
    bus.save = 1'b0;
    check("same_reg.after", 32'(bus.data_out), 32'h3C);

    // Asynchronous reset between edges while save is asserted.
    @(negedge clk);
    bus.save = 1'b1; bus.wr_sel = 2'd1; bus.alu_out = 8'h99; bus.rd_sel = 2'd1;
    #2;
    reset = 1'b0;
    #1;
    check_out("async_rst", 8'h00, 1'b1, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    check_out("rst_edge", 8'h00, 1'b1, 1'b0, 4'b0000);
    @(negedge clk);
    reset    = 1'b1;
    bus.save = 1'b0;
    #1;
    check_out("rst_release", 8'h00, 1'b1, 1'b0, 4'b0000);

    // First edge after release with save performs a normal write.
    @(negedge clk);
    bus.save = 1'b1; bus.wr_sel = 2'd1; bus.alu_out = 8'h99; bus.rd_sel = 2'd1;
    @(posedge clk);
    #1;
    bus.save = 1'b0;
    check_out("post_rst_write", 8'h99, 1'b0, 1'b1, 4'b0010);
    bus.rd_sel = 2'd0;
    #1;
    check_out("post_rst_rd0", 8'h00, 1'b1, 1'b0, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
